fir_decimator: RTL and testbench
================================

// Module: fir_decimator
// PURPOSE
//   Downstream stage of the parallel FIR filter. Consumes the filter's valid-qualified output stream.
//   Decimates it by DECIM using integrate-and-dump averaging (the FIR is the anti-alias low-pass).
//   Buffers decimated samples in a small FIFO and presents them on a valid/ready interface.
//   The FIR has no backpressure, so any loss is flagged, never stalled.
// PARAMETERS
//   IWIDTH      16  signed input sample width (matches FIR OWIDTH)
//   OWIDTH      16  signed output sample width; may be < IWIDTH (output saturates)
//   DECIM        4  decimation factor; power of two, >= 2
//   FIFO_DEPTH   4  output FIFO entries; power of two, >= 2
//   LOG2_DECIM, LOG2_DEPTH: derived localparams (clog2)
// PORTS
//   clk          in   1               clock; all logic on rising edge
//   arst_n       in   1               async reset, active low
//   in_valid     in   1               din qualifier (from FIR output_valid)
//   din          in   IWIDTH          signed FIR output sample
//   out_valid    out  1               dout holds a decimated sample
//   out_ready    in   1               consumer accepts dout when out_valid & out_ready
//   dout         out  OWIDTH          signed decimated sample (FIFO head)
//   level        out  LOG2_DEPTH+1    FIFO occupancy, 0..FIFO_DEPTH
//   overflow     out  1               sticky: a decimated sample was dropped
// BEHAVIOUR
//   Reset (arst_n=0, async assert, sync release)
//     - out_valid=0, dout=0, level=0, overflow=0; phase=0, acc=0; FIFO pointers=0.
//     - Mid-accumulation reset discards the partial sum; the next valid sample is phase 0.
//   Accumulator
//     - acc is IWIDTH+LOG2_DECIM bits signed; it cannot overflow.
//     - When in_valid: acc <= (phase==0 ? din : acc+din); phase <= phase+1 (wraps at DECIM-1 -> 0).
//     - in_valid low: acc and phase hold. Gaps in the input stream are allowed.
//   Dump (in_valid & phase==DECIM-1)
//     - sum = acc + din (sign-extended); avg = sum >>> LOG2_DECIM.
//     - avg saturates to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1] and is pushed into the FIFO on the same edge.
//     - Latency: out_valid rises the cycle after the edge that samples the DECIM-th input, when the FIFO was empty.
//   FIFO / handshake
//     - pop = out_valid & out_ready; push = dump.
//     - Registered head: dout/out_valid stable while out_valid & !out_ready.
//     - Full + push + pop in the same cycle: both occur; level unchanged; no drop.
//     - Full + push without pop: sample dropped, overflow <= 1 (cleared only by reset); FIFO contents untouched.
//     - Empty + push + pop: impossible, since out_valid=0 when empty. No fall-through; the push lands next cycle.
//     - Pointers wrap modulo FIFO_DEPTH. level = push - pop, accumulated.
// CONFIGURATION
//   DECIM_ROUND_EN
//     - Defined: round half up before shift: avg = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM, then saturate.
//     - Undefined: truncate (arithmetic shift toward -inf).
//     - Either way, latency and interface are identical.
// STRUCTURE
//   - shared_header.vh: IWIDTH/OWIDTH defaults, DECIM default, saturation min/max helper constants.
//   - Sub-module sample_fifo (params WIDTH, DEPTH): synchronous FIFO with registered head, full/empty/level.
//   - fir_decimator holds the phase counter, accumulator, round/saturate logic and the overflow flag.
// TESTING (DECIM=4, FIFO_DEPTH=4 unless noted)
//   1. Reset: arst_n=0 after 2 of 4 samples, then release and feed 4x din=8
//      -> exactly one output, dout=8; all outputs 0 during reset.
//   2. DC: din=25 continuous, out_ready=1 -> dout=25, out_valid high 1 cycle per 4 inputs, first 1 cycle after 4th input.
//   3. Alternating +200/-200, 40 samples -> 10 outputs, all dout=0.
//   4. Rounding: inputs 1,1,1,0 -> dout=0 without DECIM_ROUND_EN, dout=1 with it.
//      Inputs -1,-1,-1,0 -> dout=-1 in both builds.
//   5. Backpressure: out_ready=0, 20 samples of ramp k*4 (k=0..4 per group)
//      -> level=4, overflow=1, 5th result dropped; then out_ready=1 drains the first 4 results in order.
//   6. Saturation (OWIDTH=8): din=1000 x4 -> dout=127; din=-1000 x4 -> dout=-128; in_valid gaps hold phase.

Source files
------------

// File: rtl/fir_decimator_pkg.sv
// Shared defaults for the FIR decimator slice.
// Optional feature macro: DECIM_ROUND_EN (round half up before the averaging shift).
package fir_decimator_pkg;

    localparam int unsigned DefIwidth    = 16;
    localparam int unsigned DefOwidth    = 16;
    localparam int unsigned DefDecim     = 4;
    localparam int unsigned DefFifoDepth = 4;

endpackage

// File: rtl/fir_decimator_sample_fifo.sv
// Sample FIFO with a registered head: rdata comes straight from storage flops, so it stays
// stable while the consumer stalls. Push is refused when full unless a pop frees a slot.
module fir_decimator_sample_fifo
    import fir_decimator_pkg::*;
#(
    parameter int unsigned WIDTH = DefOwidth,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        level_d = level_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (level_q == '0);
    assign full  = (level_q == (PtrW + 1)'(DEPTH));
    assign level = level_q;

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator behind the FIR: averages DECIM valid samples, saturates to OWIDTH
// and queues the result. Define DECIM_ROUND_EN to round half up instead of truncating.
module fir_decimator
    import fir_decimator_pkg::*;
#(
    parameter int unsigned IWIDTH     = DefIwidth,
    parameter int unsigned OWIDTH     = DefOwidth,
    parameter int unsigned DECIM      = DefDecim,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          in_valid,
    input  logic [IWIDTH-1:0]             din,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OWIDTH-1:0]             dout,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int unsigned LOG2_DECIM = $clog2(DECIM);
    localparam int unsigned LOG2_DEPTH = $clog2(FIFO_DEPTH);
    localparam int unsigned AccW       = IWIDTH + LOG2_DECIM;
    // One guard bit above the accumulator so the rounding offset cannot wrap.
    localparam int unsigned SumW       = AccW + 1;
    localparam int unsigned SatW       = (SumW > OWIDTH) ? SumW : OWIDTH;
    localparam logic signed [SatW-1:0] SatMax = {{(SatW - OWIDTH + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
    localparam logic signed [SatW-1:0] SatMin = ~SatMax;

    logic [LOG2_DECIM-1:0]    phase_q, phase_d;
    logic signed [AccW-1:0]   acc_q, acc_d;
    logic                     overflow_q, overflow_d;
    logic signed [SumW-1:0]   sum, sum_r, avg;
    logic signed [SatW-1:0]   avg_ext;
    logic [OWIDTH-1:0]        sat;
    logic                     dump, pop, fifo_empty, fifo_full;

    always_comb begin
        phase_d    = phase_q;
        acc_d      = acc_q;
        dump       = in_valid && (phase_q == LOG2_DECIM'(DECIM - 1));
        pop        = out_valid && out_ready;
        overflow_d = overflow_q || (dump && fifo_full && !pop);

        sum = SumW'(acc_q) + SumW'($signed(din));
`ifdef DECIM_ROUND_EN
        sum_r = sum + SumW'(DECIM / 2);
`else
        sum_r = sum;
`endif
        avg     = sum_r >>> LOG2_DECIM;
        avg_ext = SatW'(avg);
        if (avg_ext > SatMax) begin
            sat = SatMax[OWIDTH-1:0];
        end else if (avg_ext < SatMin) begin
            sat = SatMin[OWIDTH-1:0];
        end else begin
            sat = avg_ext[OWIDTH-1:0];
        end

        if (in_valid) begin
            acc_d   = (phase_q == '0) ? AccW'($signed(din)) : acc_q + AccW'($signed(din));
            phase_d = phase_q + LOG2_DECIM'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_q    <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    fir_decimator_sample_fifo #(
        .WIDTH (OWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (dump),
        .wdata  (sat),
        .pop    (pop),
        .rdata  (dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (level)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

    logic unused_log2_depth;
    assign unused_log2_depth = ^LOG2_DEPTH;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: default instance plus an OWIDTH=8 instance for saturation.
module tb_fir_decimator;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid, out_ready, out_valid, overflow;
    logic [15:0] din, dout;
    logic [2:0]  level;
    logic        s_in_valid, s_out_ready, s_out_valid, s_overflow;
    logic [15:0] s_din;
    logic [7:0]  s_dout;
    logic [2:0]  s_level;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fir_decimator #(
        .IWIDTH (16), .OWIDTH (16), .DECIM (4), .FIFO_DEPTH (4)
    ) dut (
        .clk (clk), .arst_n (arst_n), .in_valid (in_valid), .din (din),
        .out_valid (out_valid), .out_ready (out_ready), .dout (dout),
        .level (level), .overflow (overflow)
    );

    fir_decimator #(
        .IWIDTH (16), .OWIDTH (8), .DECIM (4), .FIFO_DEPTH (4)
    ) dut_sat (
        .clk (clk), .arst_n (arst_n), .in_valid (s_in_valid), .din (s_din),
        .out_valid (s_out_valid), .out_ready (s_out_ready), .dout (s_dout),
        .level (s_level), .overflow (s_overflow)
    );

    task automatic send(input logic [15:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        din      = v;
    endtask

    task automatic send_s(input logic [15:0] v);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_din      = v;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, dout, level, overflow, s_out_valid, s_dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%0d o=%b sv=%b sd=%h want all 0",
                     out_valid, dout, level, overflow, s_out_valid, s_dout);
        end
        arst_n = 1'b1;
        send(16'd100);
        send(16'd100);
        @(posedge clk);
        #2;
        arst_n   = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, dout, level, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b d=%h l=%0d o=%b want all 0",
                     out_valid, dout, level, overflow);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 4; k++) send(16'd8);
        idle();
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'd8) begin
            errors++;
            $display("FAIL reset_first_out: got v=%b d=%0d want v=1 d=8", out_valid, dout);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || level !== 3'd0) begin
                errors++;
                $display("FAIL reset_single_out: got v=%b l=%0d want v=0 l=0", out_valid, level);
            end
        end
    endtask

    task automatic test_dc();
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (i > 0 && (i % 4) == 0)) begin
                errors++;
                $display("FAIL dc_valid[%0d]: got %b want %b", i, out_valid, (i > 0 && (i % 4) == 0));
            end
            if (i > 0 && (i % 4) == 0) begin
                checks++;
                if (dout !== 16'd25) begin
                    errors++;
                    $display("FAIL dc_dout[%0d]: got %0d want 25", i, dout);
                end
            end
            in_valid = (i < 12);
            din      = 16'd25;
        end
    endtask

    task automatic test_alternating();
        int n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_out++;
                checks++;
                if (dout !== 16'd0) begin
                    errors++;
                    $display("FAIL alt_dout[%0d]: got %0d want 0", i, $signed(dout));
                end
            end
            in_valid = (i < 40);
            din      = (i % 2 == 1) ? -16'sd200 : 16'sd200;
        end
        checks++;
        if (n_out != 10) begin
            errors++;
            $display("FAIL alt_count: got %0d outputs want 10", n_out);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] exp_pos;
`ifdef DECIM_ROUND_EN
        exp_pos = 16'd1;
`else
        exp_pos = 16'd0;
`endif
        out_ready = 1'b1;
        send(16'd1); send(16'd1); send(16'd1); send(16'd0);
        idle();
        checks++;
        if (out_valid !== 1'b1 || dout !== exp_pos) begin
            errors++;
            $display("FAIL round_pos: got v=%b d=%0d want v=1 d=%0d", out_valid, dout, exp_pos);
        end
        send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'd0);
        idle();
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'hFFFF) begin
            errors++;
            $display("FAIL round_neg: got v=%b d=%h want v=1 d=ffff", out_valid, dout);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                send(16'(g * 4));
                if (g == 4 && k == 0) begin
                    checks++;
                    if (level !== 3'd4 || overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_full: got l=%0d o=%b want l=4 o=0", level, overflow);
                    end
                end
            end
        end
        idle();
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop: got l=%0d o=%b v=%b want l=4 o=1 v=1", level, overflow, out_valid);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== 16'(j * 4)) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got v=%b d=%0d want v=1 d=%0d", j, out_valid, dout, j * 4);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: got v=%b l=%0d o=%b want v=0 l=0 o=1", out_valid, level, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_ovf_clear: got %b want 0", overflow);
        end
        for (int g = 1; g <= 4; g++) begin
            for (int k = 0; k < 4; k++) send(16'(g * 10));
        end
        for (int k = 0; k < 3; k++) send(16'd50);
        send(16'd50);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0 || dout !== 16'd20) begin
            errors++;
            $display("FAIL fpp_state: got l=%0d o=%b d=%0d want l=4 o=0 d=20", level, overflow, dout);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== 16'((j + 2) * 10)) begin
                errors++;
                $display("FAIL fpp_drain[%0d]: got v=%b d=%0d want v=1 d=%0d",
                         j, out_valid, dout, (j + 2) * 10);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_s(16'd1000);
            idle();
            idle();
            checks++;
            if (s_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL sat_gap[%0d]: got v=%b want 0", k, s_out_valid);
            end
        end
        send_s(16'd1000);
        idle();
        checks++;
        if (s_out_valid !== 1'b1 || s_dout !== 8'h7F) begin
            errors++;
            $display("FAIL sat_pos: got v=%b d=%h want v=1 d=7f", s_out_valid, s_dout);
        end
        for (int k = 0; k < 4; k++) send_s(-16'sd1000);
        idle();
        checks++;
        if (s_out_valid !== 1'b1 || s_dout !== 8'h80 || s_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_neg: got v=%b d=%h o=%b want v=1 d=80 o=0", s_out_valid, s_dout, s_overflow);
        end
    endtask

    initial begin
        arst_n      = 1'b0;
        in_valid    = 1'b0;
        din         = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_din       = '0;
        s_out_ready = 1'b0;
        test_reset();
        test_dc();
        test_alternating();
        test_rounding();
        test_backpressure();
        test_full_push_pop();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
